mc_cu: RTL and testbench

//  Multicycle control FSM for the MIPS-subset CPU (add/sub/and/or/xor/sll/srl/sra/jr,

---
 rtl/mc_defs.sv | 52 +++++
 rtl/mc_decode.sv | 42 ++++
 rtl/mc_cu.sv | 83 ++++++++
 tb/tb_mc_cu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_defs.sv
// mc_defs: opcode/func constants, state encodings and control codes for the multicycle CPU
package mc_defs;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;
  localparam logic [1:0] SB_B    = 2'b00;
  localparam logic [1:0] SB_FOUR = 2'b01;
  localparam logic [1:0] SB_IMM  = 2'b10;
  localparam logic [1:0] SB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;
  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB} state_t;
  typedef struct packed {
    logic r_alu, jr, j, jal, beq, bne, lw, sw, valid, sext, regrt, shift;
    logic [3:0] aluc;
  } dec_t;
  typedef struct packed {
    logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
  } ctrl_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: op/func to instruction class flags plus aluc/sext/regrt/shift
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       d
);
  always_comb begin
    d = '0;
    d.valid = 1'b1;
    case (op)
      OP_R: begin
        d.r_alu = 1'b1;
        case (func)
          F_ADD: d.aluc = ALU_ADD;
          F_SUB: d.aluc = ALU_SUB;
          F_AND: d.aluc = ALU_AND;
          F_OR:  d.aluc = ALU_OR;
          F_XOR: d.aluc = ALU_XOR;
          F_SLL: {d.aluc, d.shift} = {ALU_SLL, 1'b1};
          F_SRL: {d.aluc, d.shift} = {ALU_SRL, 1'b1};
          F_SRA: {d.aluc, d.shift} = {ALU_SRA, 1'b1};
          F_JR:  {d.jr, d.r_alu} = 2'b10;
          default: {d.valid, d.r_alu} = 2'b00;
        endcase
      end
      OP_ADDI: {d.aluc, d.sext, d.regrt} = {ALU_ADD, 2'b11};
      OP_ANDI: {d.aluc, d.regrt} = {ALU_AND, 1'b1};
      OP_ORI:  {d.aluc, d.regrt} = {ALU_OR, 1'b1};
      OP_XORI: {d.aluc, d.regrt} = {ALU_XOR, 1'b1};
      OP_LUI:  {d.aluc, d.regrt} = {ALU_LUI, 1'b1};
      OP_LW:   {d.lw, d.sext, d.regrt} = 3'b111;
      OP_SW:   {d.sw, d.sext} = 2'b11;
      OP_BEQ:  {d.beq, d.sext, d.aluc} = {2'b11, ALU_SUB};
      OP_BNE:  {d.bne, d.sext, d.aluc} = {2'b11, ALU_SUB};
      OP_J:    d.j = 1'b1;
      OP_JAL:  d.jal = 1'b1;
      default: d.valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_cu.sv
// mc_cu: multicycle control FSM sequencing IF/ID/EXE/MEM/WB over a shared ALU and memory
module mc_cu
  import mc_defs::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               z,
  input  logic               mem_ready,
  output logic               wpc,
  output logic               wir,
  output logic               wmem,
  output logic               wreg,
  output logic               iord,
  output logic               regrt,
  output logic               m2reg,
  output logic               jal,
  output logic               shift,
  output logic               sext,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [3:0]         aluc,
  output logic [1:0]         pcsource,
  output logic [STATE_W-1:0] state
);
  state_t cur, nxt;
  dec_t   d;
  ctrl_t  n, c;
  logic   rdy;
  mc_decode u_dec (.op(op), .func(func), .d(d));
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  always_ff @(posedge clock)
    if (reset) cur <= S_IF;
    else cur <= nxt;
  always_comb begin
    n = '0;
    nxt = S_IF;
    case (cur)
      S_IF: begin
        n.alusrcb = SB_FOUR;
        {n.wpc, n.wir} = {rdy, rdy};
        nxt = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        n.alusrcb = SB_IMM2;
        n.sext = 1'b1;
        n.wpc = d.j | d.jal | d.jr;
        n.pcsource = d.jr ? PC_RS : (d.j | d.jal) ? PC_JUMP : PC_ALU;
        {n.wreg, n.jal} = {d.jal, d.jal};
        nxt = (d.valid && !n.wpc) ? S_EXE : S_IF;
      end
      S_EXE: begin
        n.alusrca = 1'b1;
        n.aluc = d.aluc;
        n.shift = d.shift;
        n.sext = d.sext;
        n.alusrcb = (d.r_alu | d.beq | d.bne) ? SB_B : SB_IMM;
        n.pcsource = (d.beq | d.bne) ? PC_BR : PC_ALU;
        n.wpc = (d.beq & z) | (d.bne & ~z);
        nxt = (d.beq | d.bne) ? S_IF : (d.lw | d.sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        n.iord = 1'b1;
        n.wmem = d.sw;
        nxt = !rdy ? S_MEM : d.sw ? S_IF : S_WB;
      end
      S_WB: begin
        n.wreg = 1'b1;
        n.m2reg = d.lw;
        n.regrt = d.regrt;
      end
      default: ;
    endcase
    c = reset ? '0 : n;
  end
  assign {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
          alusrcb, aluc, pcsource} = c;
  assign state = STATE_W'(cur);
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: scoreboard-driven checks of the multicycle control FSM
module tb_mc_cu;
  typedef struct packed {
    logic [2:0]  st;
    logic [10:0] en;
    logic [1:0]  srcb;
    logic [3:0]  aluc;
    logic [1:0]  pcs;
  } o_t;
  typedef struct packed {
    logic rst, rdy, z;
    logic [5:0] op, func;
    o_t e;
  } ent_t;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] JAL = 6'b000011, J = 6'b000010, ORI = 6'b001101, BAD = 6'b111111;
  localparam o_t IF1    = {3'd0, 11'b11000000000, 2'b01, 4'b0000, 2'b00};
  localparam o_t IF0    = {3'd0, 11'b00000000000, 2'b01, 4'b0000, 2'b00};
  localparam o_t ID     = {3'd1, 11'b00000000010, 2'b11, 4'b0000, 2'b00};
  localparam o_t EX_LS  = {3'd2, 11'b00000000011, 2'b10, 4'b0000, 2'b00};
  localparam o_t MEM_LW = {3'd3, 11'b00001000000, 2'b00, 4'b0000, 2'b00};
  localparam o_t MEM_SW = {3'd3, 11'b00101000000, 2'b00, 4'b0000, 2'b00};
  localparam o_t WB_R   = {3'd4, 11'b00010000000, 2'b00, 4'b0000, 2'b00};
  localparam o_t WB_LW  = {3'd4, 11'b00010110000, 2'b00, 4'b0000, 2'b00};
  localparam o_t EX_BR1 = {3'd2, 11'b10000000011, 2'b00, 4'b0100, 2'b01};
  localparam o_t EX_BR0 = {3'd2, 11'b00000000011, 2'b00, 4'b0100, 2'b01};

  logic clock = 0, reset = 1, rst2 = 1, z = 0, mem_ready = 0, zero = 0;
  logic [5:0] op = 0, func = 0;
  logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;
  logic wpc2, wir2, wmem2, wreg2, iord2, regrt2, m2reg2, jal2, shift2, sext2, alusrca2;
  logic [1:0] alusrcb2, pcsource2;
  logic [3:0] aluc2;
  logic [2:0] state2;
  o_t obs, obs2;
  ent_t sb[$];
  ent_t en;
  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  mc_cu u_dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state));
  mc_cu #(.MEM_HANDSHAKE(1'b0)) u_nh (
    .clock(clock), .reset(rst2), .op(op), .func(func), .z(z), .mem_ready(zero),
    .wpc(wpc2), .wir(wir2), .wmem(wmem2), .wreg(wreg2), .iord(iord2), .regrt(regrt2),
    .m2reg(m2reg2), .jal(jal2), .shift(shift2), .sext(sext2), .alusrca(alusrca2),
    .alusrcb(alusrcb2), .aluc(aluc2), .pcsource(pcsource2), .state(state2));

  assign obs = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
                alusrcb, aluc, pcsource};
  assign obs2 = {state2, wpc2, wir2, wmem2, wreg2, iord2, regrt2, m2reg2, jal2, shift2, sext2,
                 alusrca2, alusrcb2, aluc2, pcsource2};

  task automatic push(input logic r, input logic rd, input logic zz,
                      input logic [5:0] o, input logic [5:0] f, input o_t e);
    sb.push_back({r, rd, zz, o, f, e});
  endtask

  task automatic test_reset;
    reset = 1;
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_chk++;
      if (obs[18:0] !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d got %h want 0", i, obs[18:0]);
      end
    end
    @(posedge clock); #1;
    reset = 0;
    n_chk++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
  endtask

  task automatic test_r_alu;
    push(0, 1, 0, 6'b0, 6'b100000, IF1);
    push(0, 1, 0, 6'b0, 6'b100000, ID);
    push(0, 1, 0, 6'b0, 6'b100000, {3'd2, 11'b00000000001, 2'b00, 4'b0000, 2'b00});
    push(0, 1, 0, 6'b0, 6'b100000, WB_R);
    push(0, 1, 0, 6'b0, 6'b000011, IF1);
    push(0, 1, 0, 6'b0, 6'b000011, ID);
    push(0, 1, 0, 6'b0, 6'b000011, {3'd2, 11'b00000000101, 2'b00, 4'b1111, 2'b00});
    push(0, 1, 0, 6'b0, 6'b000011, WB_R);
    push(0, 1, 0, ORI, 6'b0, IF1);
    push(0, 1, 0, ORI, 6'b0, ID);
    push(0, 1, 0, ORI, 6'b0, {3'd2, 11'b00000000001, 2'b10, 4'b0101, 2'b00});
    push(0, 1, 0, ORI, 6'b0, {3'd4, 11'b00010100000, 2'b00, 4'b0000, 2'b00});
    for (int k = 0; sb.size() > 0; k++) begin
      en = sb.pop_front();
      {reset, mem_ready, z, op, func} = {en.rst, en.rdy, en.z, en.op, en.func};
      @(negedge clock);
      n_chk++;
      if (obs !== en.e) begin n_fail++; $display("FAIL r_alu cyc%0d got %h want %h", k, obs, en.e); end
      @(posedge clock); #1;
    end
    n_chk++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL r_alu_end state got %0d want 0", state); end
  endtask

  task automatic test_lw_wait;
    push(0, 0, 0, LW, 0, IF0);
    push(0, 0, 0, LW, 0, IF0);
    push(0, 1, 0, LW, 0, IF1);
    push(0, 1, 0, LW, 0, ID);
    push(0, 1, 0, LW, 0, EX_LS);
    push(0, 0, 0, LW, 0, MEM_LW);
    push(0, 0, 0, LW, 0, MEM_LW);
    push(0, 0, 0, LW, 0, MEM_LW);
    push(0, 1, 0, LW, 0, MEM_LW);
    push(0, 1, 0, LW, 0, WB_LW);
    for (int k = 0; sb.size() > 0; k++) begin
      en = sb.pop_front();
      {reset, mem_ready, z, op, func} = {en.rst, en.rdy, en.z, en.op, en.func};
      @(negedge clock);
      n_chk++;
      if (obs !== en.e) begin n_fail++; $display("FAIL lw_wait cyc%0d got %h want %h", k, obs, en.e); end
      @(posedge clock); #1;
    end
    n_chk++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL lw_end state got %0d want 0", state); end
  endtask

  task automatic test_sw;
    push(0, 1, 0, SW, 0, IF1);
    push(0, 1, 0, SW, 0, ID);
    push(0, 1, 0, SW, 0, EX_LS);
    push(0, 0, 0, SW, 0, MEM_SW);
    push(0, 1, 0, SW, 0, MEM_SW);
    for (int k = 0; sb.size() > 0; k++) begin
      en = sb.pop_front();
      {reset, mem_ready, z, op, func} = {en.rst, en.rdy, en.z, en.op, en.func};
      @(negedge clock);
      n_chk++;
      if (obs !== en.e) begin n_fail++; $display("FAIL sw cyc%0d got %h want %h", k, obs, en.e); end
      @(posedge clock); #1;
    end
    n_chk++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL sw_end state got %0d want 0", state); end
  endtask

  task automatic test_branch;
    push(0, 1, 1, BEQ, 0, IF1); push(0, 1, 1, BEQ, 0, ID); push(0, 1, 1, BEQ, 0, EX_BR1);
    push(0, 1, 0, BEQ, 0, IF1); push(0, 1, 0, BEQ, 0, ID); push(0, 1, 0, BEQ, 0, EX_BR0);
    push(0, 1, 1, BNE, 0, IF1); push(0, 1, 1, BNE, 0, ID); push(0, 1, 1, BNE, 0, EX_BR0);
    push(0, 1, 0, BNE, 0, IF1); push(0, 1, 0, BNE, 0, ID); push(0, 1, 0, BNE, 0, EX_BR1);
    for (int k = 0; sb.size() > 0; k++) begin
      en = sb.pop_front();
      {reset, mem_ready, z, op, func} = {en.rst, en.rdy, en.z, en.op, en.func};
      @(negedge clock);
      n_chk++;
      if (obs !== en.e) begin n_fail++; $display("FAIL branch cyc%0d got %h want %h", k, obs, en.e); end
      @(posedge clock); #1;
    end
    n_chk++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL branch_end state got %0d want 0", state); end
  endtask

  task automatic test_jump;
    push(0, 1, 0, JAL, 0, IF1);
    push(0, 1, 0, JAL, 0, {3'd1, 11'b10010001010, 2'b11, 4'b0000, 2'b11});
    push(0, 1, 0, J, 0, IF1);
    push(0, 1, 0, J, 0, {3'd1, 11'b10000000010, 2'b11, 4'b0000, 2'b11});
    push(0, 1, 0, 6'b0, 6'b001000, IF1);
    push(0, 1, 0, 6'b0, 6'b001000, {3'd1, 11'b10000000010, 2'b11, 4'b0000, 2'b10});
    push(0, 1, 0, BAD, 0, IF1);
    push(0, 1, 0, BAD, 0, ID);
    push(0, 0, 0, BAD, 0, IF0);
    for (int k = 0; sb.size() > 0; k++) begin
      en = sb.pop_front();
      {reset, mem_ready, z, op, func} = {en.rst, en.rdy, en.z, en.op, en.func};
      @(negedge clock);
      n_chk++;
      if (obs !== en.e) begin n_fail++; $display("FAIL jump cyc%0d got %h want %h", k, obs, en.e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_in_mem;
    push(0, 1, 0, SW, 0, IF1);
    push(0, 1, 0, SW, 0, ID);
    push(0, 1, 0, SW, 0, EX_LS);
    push(1, 0, 0, SW, 0, {3'd3, 11'b0, 2'b00, 4'b0000, 2'b00});
    push(0, 0, 0, SW, 0, IF0);
    for (int k = 0; sb.size() > 0; k++) begin
      en = sb.pop_front();
      {reset, mem_ready, z, op, func} = {en.rst, en.rdy, en.z, en.op, en.func};
      @(negedge clock);
      n_chk++;
      if (obs !== en.e) begin n_fail++; $display("FAIL reset_mem cyc%0d got %h want %h", k, obs, en.e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_no_handshake;
    op = LW;
    rst2 = 1;
    @(posedge clock); #1;
    rst2 = 0;
    push(0, 0, 0, LW, 0, IF1);
    push(0, 0, 0, LW, 0, ID);
    push(0, 0, 0, LW, 0, EX_LS);
    push(0, 0, 0, LW, 0, MEM_LW);
    push(0, 0, 0, LW, 0, WB_LW);
    for (int k = 0; sb.size() > 0; k++) begin
      en = sb.pop_front();
      {z, op, func} = {en.z, en.op, en.func};
      @(negedge clock);
      n_chk++;
      if (obs2 !== en.e) begin n_fail++; $display("FAIL no_handshake cyc%0d got %h want %h", k, obs2, en.e); end
      @(posedge clock); #1;
    end
    n_chk++;
    if (state2 !== 3'd0) begin n_fail++; $display("FAIL no_handshake_end state got %0d want 0", state2); end
  endtask

  initial begin
    test_reset;
    test_r_alu;
    test_lw_wait;
    test_sw;
    test_branch;
    test_jump;
    test_reset_in_mem;
    test_no_handshake;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
